// File: rtl/scaleable_demux_buf_pkg.sv
// Shared definitions for the buffered 1-to-N demultiplexer: lane FIFO depth,
// flat-bus slice arithmetic and the select-width legality check.
package scaleable_demux_buf_pkg;

    // Every output lane buffers up to two words.
    localparam int LANE_FIFO_DEPTH = 2;

    // Base bit index of lane 'lane' on the flat out_data bus.
    function automatic int lane_base(input int lane, input int dw);
        return lane * dw;
    endfunction

    // The select field must be wide enough to address every lane.
    function automatic bit sel_width_ok(input int n, input int sw);
        return (sw >= $clog2(n));
    endfunction

endpackage

// File: rtl/scaleable_demux_buf_fifo.sv
// Depth-2 first-in first-out lane buffer. The head word is held in a register
// and is forced to zero whenever the buffer is empty. A push is ignored while
// the buffer is full, and a pop is ignored while it is empty.
module demux_lane_fifo
    import scaleable_demux_buf_pkg::*;
#(
    parameter int data_width = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  push,
    input  logic [data_width-1:0] push_data,
    input  logic                  pop,
    output logic [data_width-1:0] head_data,
    output logic                  empty,
    output logic                  full
);

    localparam int CW = $clog2(LANE_FIFO_DEPTH + 1);
    localparam logic [CW-1:0] CNT_EMPTY = CW'(0);
    localparam logic [CW-1:0] CNT_ONE   = CW'(1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(LANE_FIFO_DEPTH);
    localparam logic [data_width-1:0] DATA_ZERO = {data_width{1'b0}};

    logic [CW-1:0]         count_r;
    logic [data_width-1:0] head_r;
    logic [data_width-1:0] tail_r;

    // Occupancy and storage update; the head always holds the oldest word.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_r <= CNT_EMPTY;
            head_r  <= DATA_ZERO;
            tail_r  <= DATA_ZERO;
        end else begin
            case (count_r)
                CNT_EMPTY: begin
                    if (push) begin
                        head_r  <= push_data;
                        count_r <= CNT_ONE;
                    end
                end
                CNT_ONE: begin
                    if (push && pop) begin
                        head_r <= push_data;
                    end else if (push) begin
                        tail_r  <= push_data;
                        count_r <= CNT_FULL;
                    end else if (pop) begin
                        head_r  <= DATA_ZERO;
                        count_r <= CNT_EMPTY;
                    end
                end
                CNT_FULL: begin
                    if (pop) begin
                        head_r  <= tail_r;
                        tail_r  <= DATA_ZERO;
                        count_r <= CNT_ONE;
                    end
                end
                default: begin
                    count_r <= CNT_EMPTY;
                    head_r  <= DATA_ZERO;
                    tail_r  <= DATA_ZERO;
                end
            endcase
        end
    end

    assign head_data = head_r;
    assign empty     = (count_r == CNT_EMPTY);
    assign full      = (count_r == CNT_FULL);

endmodule

// File: rtl/scaleable_demux_buf.sv
// Buffered 1-to-N demultiplexer. Each word is steered to the lane named by
// in_sel, and every lane has its own depth-2 FIFO. A word whose select value
// is out of range is accepted, discarded and counted. in_ready depends only on
// in_sel and on registered lane state.
module scaleable_demux_buf
    import scaleable_demux_buf_pkg::*;
#(
    parameter int N          = 8,
    parameter int sel_width  = 3,
    parameter int data_width = 8,
    parameter int cnt_width  = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [data_width-1:0]   in_data,
    input  logic [sel_width-1:0]    in_sel,
    output logic [N-1:0]            out_valid,
    input  logic [N-1:0]            out_ready,
    output logic [N*data_width-1:0] out_data,
    output logic                    drop_pulse,
    output logic [cnt_width-1:0]    drop_count
);

    if (!sel_width_ok(N, sel_width)) begin : g_bad_sel_width
        $error("scaleable_demux_buf: sel_width too narrow to address N lanes");
    end

    localparam logic [cnt_width-1:0] CNT_MAX = {cnt_width{1'b1}};
    localparam logic [cnt_width-1:0] CNT_ONE = cnt_width'(1);

    logic [N-1:0]         sel_match_s;
    logic [N-1:0]         empty_s;
    logic [N-1:0]         full_s;
    logic [N-1:0]         push_s;
    logic [N-1:0]         pop_s;
    logic                 sel_in_range_s;
    logic                 lane_full_s;
    logic                 in_ready_s;
    logic                 xfer_s;
    logic                 drop_s;
    logic                 drop_pulse_r;
    logic [cnt_width-1:0] drop_count_r;

    // Full-width unsigned select decode, ready mux and per-lane push/pop strobes.
    always_comb begin
        sel_match_s = {N{1'b0}};
        for (int i = 0; i < N; i++) begin
            sel_match_s[i] = (in_sel == sel_width'(i));
        end
        sel_in_range_s = |sel_match_s;
        lane_full_s    = |(sel_match_s & full_s);
        in_ready_s     = sel_in_range_s ? !lane_full_s : 1'b1;
        xfer_s         = in_valid && in_ready_s;
        drop_s         = xfer_s && !sel_in_range_s;
        push_s         = sel_match_s & {N{xfer_s}};
        pop_s          = ~empty_s & out_ready;
    end

    for (genvar g = 0; g < N; g++) begin : g_lane
        demux_lane_fifo #(
            .data_width(data_width)
        ) u_fifo (
            .clk       (clk),
            .reset     (reset),
            .push      (push_s[g]),
            .push_data (in_data),
            .pop       (pop_s[g]),
            .head_data (out_data[lane_base(g, data_width) +: data_width]),
            .empty     (empty_s[g]),
            .full      (full_s[g])
        );
    end

    // Drop notification pulse and saturating drop counter.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            drop_pulse_r <= 1'b0;
            drop_count_r <= {cnt_width{1'b0}};
        end else begin
            drop_pulse_r <= drop_s;
            if (drop_s && (drop_count_r != CNT_MAX)) begin
                drop_count_r <= drop_count_r + CNT_ONE;
            end else begin
                drop_count_r <= drop_count_r;
            end
        end
    end

    assign in_ready   = in_ready_s;
    assign out_valid  = ~empty_s;
    assign drop_pulse = drop_pulse_r;
    assign drop_count = drop_count_r;

endmodule

// File: tb/tb_scaleable_demux_buf.sv
// Scoreboard bench for scaleable_demux_buf (N=6, sel_width=3, data_width=8,
// cnt_width=4). The stimulus process records accepted words in per-lane
// expected queues. A separate monitor compares lane outputs and drop status
// with those queues on every cycle.
module tb_scaleable_demux_buf;

    localparam int N  = 6;
    localparam int SW = 3;
    localparam int DW = 8;
    localparam int CW = 4;

    logic            clk = 1'b0;
    logic            reset;
    logic            in_valid;
    logic            in_ready;
    logic [DW-1:0]   in_data;
    logic [SW-1:0]   in_sel;
    logic [N-1:0]    out_valid;
    logic [N-1:0]    out_ready;
    logic [N*DW-1:0] out_data;
    logic            drop_pulse;
    logic [CW-1:0]   drop_count;

    always #5 clk = ~clk;

    scaleable_demux_buf #(.N(N), .sel_width(SW), .data_width(DW), .cnt_width(CW)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_sel     (in_sel),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .drop_pulse (drop_pulse),
        .drop_count (drop_count)
    );

    int checks = 0;
    int errors = 0;
    logic [DW-1:0] lane_q [N][$];
    bit            pend_v;
    int            pend_lane;
    logic [DW-1:0] pend_data;
    bit            pend_drop;
    bit            exp_pulse;
    int            exp_cnt;
    int            accepted;
    int            delivered;
    bit            mon_en;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // The previous cycle's handshake has now happened at the edge: apply it to the model.
    task automatic commit();
        if (pend_v) lane_q[pend_lane].push_back(pend_data);
        exp_pulse = pend_drop;
        if (pend_drop && exp_cnt < 15) exp_cnt++;
        pend_v    = 1'b0;
        pend_drop = 1'b0;
    endtask

    // Drive one cycle of stimulus and predict in_ready from the model occupancy.
    task automatic step(input bit v, input int s, input logic [DW-1:0] d,
                        input logic [N-1:0] r, output bit acc);
        bit er;
        @(posedge clk);
        #1;
        commit();
        in_valid  = v;
        in_sel    = s[SW-1:0];
        in_data   = d;
        out_ready = r;
        #1;
        er = (s >= N) ? 1'b1 : (lane_q[s].size() < 2);
        chk($sformatf("in_ready_sel%0d", s), {31'b0, in_ready}, {31'b0, er});
        acc = v && er;
        if (acc) begin
            if (s < N) begin
                pend_v    = 1'b1;
                pend_lane = s;
                pend_data = d;
                accepted++;
            end else begin
                pend_drop = 1'b1;
            end
        end
    endtask

    // Assert reset between clock edges and check that it clears the outputs at once.
    task automatic do_reset();
        @(posedge clk);
        #4;
        reset = 1'b1;
        #1;
        chk("rst_async_out_valid", 32'(out_valid), 32'h0);
        chk("rst_async_drop_count", 32'(drop_count), 32'h0);
        chk("rst_async_out_data_zero", {31'b0, (out_data == {(N*DW){1'b0}})}, 32'h1);
        in_valid = 1'b0;
        for (int i = 0; i < N; i++) lane_q[i].delete();
        pend_v    = 1'b0;
        pend_drop = 1'b0;
        exp_pulse = 1'b0;
        exp_cnt   = 0;
        repeat (2) @(posedge clk);
        #4;
        reset = 1'b0;
    endtask

    // Monitor: compare every lane with the expected queues and retire popped words.
    always @(posedge clk) begin : monitor
        bit            ev;
        logic [DW-1:0] ed;
        #3;
        if (mon_en && !reset) begin
            for (int i = 0; i < N; i++) begin
                ev = (lane_q[i].size() > 0);
                ed = ev ? lane_q[i][0] : 8'h00;
                chk($sformatf("lane%0d_valid", i), {31'b0, out_valid[i]}, {31'b0, ev});
                chk($sformatf("lane%0d_data", i), {24'b0, out_data[i*DW +: DW]}, {24'b0, ed});
                if (ev && out_ready[i]) begin
                    void'(lane_q[i].pop_front());
                    delivered++;
                end
            end
            chk("drop_pulse", {31'b0, drop_pulse}, {31'b0, exp_pulse});
            chk("drop_count", 32'(drop_count), 32'(exp_cnt));
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        bit acc;
        int total_q;
        reset = 1'b1; in_valid = 1'b0; in_sel = 3'd0; in_data = 8'h00; out_ready = 6'b000000;
        pend_v = 1'b0; pend_drop = 1'b0; exp_pulse = 1'b0; exp_cnt = 0;
        accepted = 0; delivered = 0; mon_en = 1'b0;

        @(posedge clk);
        #1;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_drop_pulse", {31'b0, drop_pulse}, 32'h0);
        chk("reset_drop_count", 32'(drop_count), 32'h0);
        chk("reset_out_data_zero", {31'b0, (out_data == {(N*DW){1'b0}})}, 32'h1);
        @(posedge clk);
        #4;
        reset  = 1'b0;
        mon_en = 1'b1;

        // Load lanes 2 and 5 with two words each and record one drop, then reset.
        step(1'b1, 2, 8'hA1, 6'b011011, acc);
        step(1'b1, 5, 8'hB1, 6'b011011, acc);
        step(1'b1, 7, 8'h77, 6'b011011, acc);
        step(1'b1, 2, 8'hA2, 6'b011011, acc);
        step(1'b1, 5, 8'hB2, 6'b011011, acc);
        step(1'b0, 0, 8'h00, 6'b011011, acc);
        chk("pre_reset_valid", 32'(out_valid), 32'h24);
        chk("pre_reset_drop_count", 32'(drop_count), 32'h1);
        do_reset();
        for (int s = 0; s < N; s++) step(1'b0, s, 8'h00, 6'b111111, acc);

        // A single word is dispatched to lane 3.
        step(1'b1, 3, 8'hA5, 6'b111111, acc);
        step(1'b0, 0, 8'h00, 6'b111111, acc);
        chk("single_valid", 32'(out_valid), 32'h08);
        chk("single_data", {24'b0, out_data[3*DW +: DW]}, 32'hA5);
        step(1'b0, 0, 8'h00, 6'b111111, acc);
        chk("single_gone", 32'(out_valid), 32'h0);

        // Lane 1 fills under backpressure while lane 4 keeps flowing.
        step(1'b1, 1, 8'h11, 6'b111101, acc);
        step(1'b1, 1, 8'h22, 6'b111101, acc);
        step(1'b1, 1, 8'h33, 6'b111101, acc);
        chk("bp_full_refuses", {31'b0, in_ready}, 32'h0);
        step(1'b1, 4, 8'h44, 6'b111101, acc);
        chk("bp_lane4_ready", {31'b0, in_ready}, 32'h1);
        step(1'b0, 0, 8'h00, 6'b111101, acc);
        chk("bp_lane4_data", {24'b0, out_data[4*DW +: DW]}, 32'h44);
        chk("bp_lane1_head", {24'b0, out_data[1*DW +: DW]}, 32'h11);
        acc = 1'b0;
        for (int k = 0; k < 5 && !acc; k++) step(1'b1, 1, 8'h33, 6'b111111, acc);
        chk("bp_33_accepted", {31'b0, acc}, 32'h1);
        repeat (3) step(1'b0, 0, 8'h00, 6'b111111, acc);

        // Lane 0 pops its old word in the same cycle that 0x55 is pushed.
        step(1'b1, 0, 8'h66, 6'b111110, acc);
        step(1'b0, 0, 8'h00, 6'b111110, acc);
        step(1'b1, 0, 8'h55, 6'b111111, acc);
        chk("pp_old_word", {24'b0, out_data[0 +: DW]}, 32'h66);
        step(1'b0, 0, 8'h00, 6'b111111, acc);
        chk("pp_still_valid", {31'b0, out_valid[0]}, 32'h1);
        chk("pp_new_word", {24'b0, out_data[0 +: DW]}, 32'h55);
        step(1'b0, 0, 8'h00, 6'b111111, acc);

        // 17 out-of-range words saturate the 4-bit drop counter.
        for (int k = 0; k < 17; k++) step(1'b1, 6 + (k % 2), 8'(k), 6'b111111, acc);
        step(1'b0, 0, 8'h00, 6'b111111, acc);
        chk("drop_saturated", 32'(drop_count), 32'hF);
        chk("drop_no_valid", 32'(out_valid), 32'h0);

        // Random stream with random downstream readiness.
        accepted  = 0;
        delivered = 0;
        for (int k = 0; k < 600; k++) begin
            step(1'($urandom_range(0, 1)), int'($urandom_range(0, 5)), 8'($urandom),
                 6'($urandom), acc);
        end
        repeat (6) step(1'b0, 0, 8'h00, 6'b111111, acc);
        total_q = 0;
        for (int i = 0; i < N; i++) total_q += lane_q[i].size();
        chk("rand_queues_drained", 32'(total_q), 32'h0);
        chk("rand_delivered_count", 32'(delivered), 32'(accepted));

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
